// File: rtl/cpu_control_sequencer_if.sv
// Control-strobe bundle between the CPU control sequencer and the datapath/memory.
// master: sequencer side (drives strobes, reads IR and mem_done).
// slave:  datapath/memory side.
interface cpu_control_sequencer_if #(
    parameter int NREGS = 16
);
    logic [31:0]      ir;
    logic             mem_done;
    logic [NREGS-1:0] reg_in;
    logic [NREGS-1:0] reg_out;
    logic             pc_in;
    logic             pc_out;
    logic             ir_in;
    logic             y_in;
    logic             z_in;
    logic             zlo_out;
    logic             mar_in;
    logic             mdr_in;
    logic             mdr_out;
    logic             c_out;
    logic             incpc;
    logic [4:0]       alu_sel;
    logic             mem_rd;
    logic             mem_wr;
    logic             halted;
    logic             fault;

    modport master (
        input  ir, mem_done,
        output reg_in, reg_out, pc_in, pc_out, ir_in, y_in, z_in, zlo_out,
               mar_in, mdr_in, mdr_out, c_out, incpc, alu_sel,
               mem_rd, mem_wr, halted, fault
    );

    modport slave (
        output ir, mem_done,
        input  reg_in, reg_out, pc_in, pc_out, ir_in, y_in, z_in, zlo_out,
               mar_in, mdr_in, mdr_out, c_out, incpc, alu_sel,
               mem_rd, mem_wr, halted, fault
    );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control sequencer for the CPU datapath: fetch, decode and execute
// steps T0..T7 with a memory handshake on every MDR load and memory write.
// Optional memory-request timeout: define CU_MEM_TIMEOUT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_T0    | PC to MAR, PC+1 into Z (held idle for one cycle after clr)
// S_T1    | Z into PC
// S_T1W   | instruction read, wait for mem_done, MDR load on done
// S_T2    | MDR into IR
// S_T3    | decode; Rb to Y for ALU/addi/ld/st
// S_T4    | second operand (Rc or constant) through ALU into Z
// S_T5    | Z to Ra (ALU/addi) or to MAR (ld/st)
// S_T6    | st: Ra into MDR
// S_T6W   | ld: data read, wait for mem_done, MDR load on done
// S_T7    | ld: MDR into Ra
// S_T7W   | st: memory write, wait for mem_done
// S_HALT  | stopped until clr
// S_FAULT | memory timeout, stopped until clr
module cpu_control_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int NREGS       = 16
) (
    input  logic                  clk,
    input  logic                  clr,
    cpu_control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5,
        S_T6, S_T6W, S_T7, S_T7W, S_HALT, S_FAULT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, state_nx;
    logic       rst_hold;
    logic [4:0] op_q, op;
    logic [3:0] ra_q, rb_q, rc_q, ra, rb, rc;
    logic       is_alu, is_addi, is_ld, is_st, is_halt, is_exec;
    logic       tmo;
    logic       unused_ir;

    logic [NREGS-1:0] reg_in_d, reg_out_d;
    logic [4:0]       alu_sel_d;
    logic pc_in_d, pc_out_d, ir_in_d, y_in_d, z_in_d, zlo_out_d, mar_in_d;
    logic mdr_in_d, mdr_out_d, c_out_d, incpc_d, mem_rd_d, mem_wr_d, halted_d, fault_d;

    // In T3 the freshly loaded IR is decoded directly; later steps use the copy taken in T3.
    assign op = (state == S_T3) ? bus.ir[31:27] : op_q;
    assign ra = (state == S_T3) ? bus.ir[26:23] : ra_q;
    assign rb = (state == S_T3) ? bus.ir[22:19] : rb_q;
    assign rc = (state == S_T3) ? bus.ir[18:15] : rc_q;
    assign unused_ir = ^bus.ir[14:0];

    assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_addi = (op == OP_ADDI);
    assign is_ld   = (op == OP_LD);
    assign is_st   = (op == OP_ST);
    assign is_halt = (op == OP_HALT);
    assign is_exec = is_alu || is_addi || is_ld || is_st;

`ifdef CU_MEM_TIMEOUT_EN
    localparam int CW = (MEM_TIMEOUT < 16) ? 4 : $clog2(MEM_TIMEOUT + 1);
    logic          in_wait;
    logic [CW-1:0] tmo_cnt;

    assign in_wait = (state == S_T1W) || (state == S_T6W) || (state == S_T7W);
    // mem_done in the terminal cycle still completes the access.
    assign tmo     = in_wait && !bus.mem_done && (tmo_cnt == '0);

    // Down-counter reloaded outside wait states, so each wait starts fresh.
    always_ff @(posedge clk) begin
        if (clr)
            tmo_cnt <= '0;
        else if (!in_wait)
            tmo_cnt <= CW'(MEM_TIMEOUT - 1);
        else if (tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - 1'b1;
    end
`else
    localparam int unused_mem_timeout = MEM_TIMEOUT;
    assign tmo = 1'b0;
`endif

    // State register, post-reset idle flag and instruction-field capture.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_T0;
            rst_hold <= 1'b1;
            op_q     <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
        end else begin
            state    <= state_nx;
            rst_hold <= 1'b0;
            if (state == S_T3) begin
                op_q <= bus.ir[31:27];
                ra_q <= bus.ir[26:23];
                rb_q <= bus.ir[22:19];
                rc_q <= bus.ir[18:15];
            end
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_nx = state;
        case (state)
            S_T0:    state_nx = rst_hold ? S_T0 : S_T1;
            S_T1:    state_nx = S_T1W;
            S_T1W:   if (bus.mem_done) state_nx = S_T2;
                     else if (tmo)     state_nx = S_FAULT;
            S_T2:    state_nx = S_T3;
            S_T3:    if (is_exec)      state_nx = S_T4;
                     else if (is_halt) state_nx = S_HALT;
                     else              state_nx = S_T0;
            S_T4:    state_nx = S_T5;
            S_T5:    if (is_ld)        state_nx = S_T6W;
                     else if (is_st)   state_nx = S_T6;
                     else              state_nx = S_T0;
            S_T6:    state_nx = S_T7W;
            S_T6W:   if (bus.mem_done) state_nx = S_T7;
                     else if (tmo)     state_nx = S_FAULT;
            S_T7:    state_nx = S_T0;
            S_T7W:   if (bus.mem_done) state_nx = S_T0;
                     else if (tmo)     state_nx = S_FAULT;
            S_HALT:  state_nx = S_HALT;
            S_FAULT: state_nx = S_FAULT;
            default: state_nx = S_T0;
        endcase
    end

    // Strobes decoded from state and instruction fields; mdr_in follows mem_done in wait states.
    always_comb begin
        reg_in_d  = '0;
        reg_out_d = '0;
        alu_sel_d = '0;
        pc_in_d   = 1'b0;
        pc_out_d  = 1'b0;
        ir_in_d   = 1'b0;
        y_in_d    = 1'b0;
        z_in_d    = 1'b0;
        zlo_out_d = 1'b0;
        mar_in_d  = 1'b0;
        mdr_in_d  = 1'b0;
        mdr_out_d = 1'b0;
        c_out_d   = 1'b0;
        incpc_d   = 1'b0;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        halted_d  = 1'b0;
        fault_d   = 1'b0;
        case (state)
            S_T0: if (!rst_hold) begin
                pc_out_d = 1'b1;
                mar_in_d = 1'b1;
                incpc_d  = 1'b1;
                z_in_d   = 1'b1;
            end
            S_T1: begin
                zlo_out_d = 1'b1;
                pc_in_d   = 1'b1;
            end
            S_T1W, S_T6W: begin
                mem_rd_d = 1'b1;
                mdr_in_d = bus.mem_done;
            end
            S_T2: begin
                mdr_out_d = 1'b1;
                ir_in_d   = 1'b1;
            end
            S_T3: if (is_exec) begin
                reg_out_d = NREGS'(1) << rb;
                y_in_d    = 1'b1;
            end
            S_T4: begin
                z_in_d = 1'b1;
                if (is_alu) begin
                    reg_out_d = NREGS'(1) << rc;
                    alu_sel_d = op;
                end else begin
                    c_out_d   = 1'b1;
                    alu_sel_d = OP_ADD;
                end
            end
            S_T5: begin
                zlo_out_d = 1'b1;
                if (is_ld || is_st) mar_in_d = 1'b1;
                else                reg_in_d = NREGS'(1) << ra;
            end
            S_T6: begin
                reg_out_d = NREGS'(1) << ra;
                mdr_in_d  = 1'b1;
            end
            S_T7: begin
                mdr_out_d = 1'b1;
                reg_in_d  = NREGS'(1) << ra;
            end
            S_T7W:   mem_wr_d = 1'b1;
            S_HALT:  halted_d = 1'b1;
            S_FAULT: fault_d  = 1'b1;
            default: ;
        endcase
    end

    assign bus.reg_in  = reg_in_d;
    assign bus.reg_out = reg_out_d;
    assign bus.alu_sel = alu_sel_d;
    assign bus.pc_in   = pc_in_d;
    assign bus.pc_out  = pc_out_d;
    assign bus.ir_in   = ir_in_d;
    assign bus.y_in    = y_in_d;
    assign bus.z_in    = z_in_d;
    assign bus.zlo_out = zlo_out_d;
    assign bus.mar_in  = mar_in_d;
    assign bus.mdr_in  = mdr_in_d;
    assign bus.mdr_out = mdr_out_d;
    assign bus.c_out   = c_out_d;
    assign bus.incpc   = incpc_d;
    assign bus.mem_rd  = mem_rd_d;
    assign bus.mem_wr  = mem_wr_d;
    assign bus.halted  = halted_d;
`ifdef CU_MEM_TIMEOUT_EN
    assign bus.fault   = fault_d;
`else
    assign bus.fault   = 1'b0;
    logic unused_fault;
    assign unused_fault = fault_d;
`endif
endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Directed bench for cpu_control_sequencer: per-cycle strobe checks for every
// instruction class, wait-state handling, halt, clr priority and (when
// CU_MEM_TIMEOUT_EN is defined) the memory timeout.
module tb_cpu_control_sequencer;
    localparam logic [14:0] PC_IN   = 15'h4000;
    localparam logic [14:0] PC_OUT  = 15'h2000;
    localparam logic [14:0] IR_IN   = 15'h1000;
    localparam logic [14:0] Y_IN    = 15'h0800;
    localparam logic [14:0] Z_IN    = 15'h0400;
    localparam logic [14:0] ZLO_OUT = 15'h0200;
    localparam logic [14:0] MAR_IN  = 15'h0100;
    localparam logic [14:0] MDR_IN  = 15'h0080;
    localparam logic [14:0] MDR_OUT = 15'h0040;
    localparam logic [14:0] C_OUT   = 15'h0020;
    localparam logic [14:0] INCPC   = 15'h0010;
    localparam logic [14:0] MEM_RD  = 15'h0008;
    localparam logic [14:0] MEM_WR  = 15'h0004;
    localparam logic [14:0] HALTED  = 15'h0002;
    localparam logic [14:0] FLT     = 15'h0001;
    localparam logic [14:0] FETCH0  = PC_OUT | MAR_IN | INCPC | Z_IN;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;

    cpu_control_sequencer_if #(.NREGS(16)) bus ();

    cpu_control_sequencer #(.MEM_TIMEOUT(15), .NREGS(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [51:0] obs();
        return {bus.pc_in, bus.pc_out, bus.ir_in, bus.y_in, bus.z_in, bus.zlo_out,
                bus.mar_in, bus.mdr_in, bus.mdr_out, bus.c_out, bus.incpc,
                bus.mem_rd, bus.mem_wr, bus.halted, bus.fault,
                bus.reg_in, bus.reg_out, bus.alu_sel};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of the sequence: drive mem_done, check outputs mid-cycle, advance.
    task automatic cyc(input string tag, input logic done, input logic [14:0] s,
                       input logic [15:0] rin, input logic [15:0] rout, input logic [4:0] alu);
        bus.mem_done = done;
        @(negedge clk);
        check(tag, {12'h0, obs()}, {12'h0, s, rin, rout, alu});
        @(posedge clk); #1;
        bus.mem_done = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bus.mem_done = 1'b0;
        @(negedge clk);
        check(tag, {12'h0, obs()}, 64'h0);
        @(posedge clk); #1;
    endtask

    // T0..T2 with mem_done on wait cycle nwait; IR takes the new word at the end of T2.
    task automatic fetch(input string pfx, input logic [31:0] irv, input int nwait);
        cyc({pfx, ".T0"}, 1'b0, FETCH0, 16'h0, 16'h0, 5'h0);
        cyc({pfx, ".T1"}, 1'b0, ZLO_OUT | PC_IN, 16'h0, 16'h0, 5'h0);
        for (int i = 1; i < nwait; i++)
            cyc({pfx, ".T1W"}, 1'b0, MEM_RD, 16'h0, 16'h0, 5'h0);
        cyc({pfx, ".T1Wd"}, 1'b1, MEM_RD | MDR_IN, 16'h0, 16'h0, 5'h0);
        cyc({pfx, ".T2"}, 1'b0, MDR_OUT | IR_IN, 16'h0, 16'h0, 5'h0);
        bus.ir = irv;
    endtask

    task automatic exec_alu(input string pfx, input logic [31:0] irv, input int nwait,
                            input logic [15:0] rb_oh, input logic [15:0] rc_oh,
                            input logic [15:0] ra_oh, input logic [4:0] alu, input bit imm);
        fetch(pfx, irv, nwait);
        cyc({pfx, ".T3"}, 1'b0, Y_IN, 16'h0, rb_oh, 5'h0);
        cyc({pfx, ".T4"}, 1'b0, imm ? (C_OUT | Z_IN) : Z_IN, 16'h0, rc_oh, alu);
        cyc({pfx, ".T5"}, 1'b0, ZLO_OUT, ra_oh, 16'h0, 5'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr = 1'b1;
        bus.ir = 32'h0;
        bus.mem_done = 1'b0;

        do_reset("reset");

        // add R1,R2,R3 ; sub R5,R9,R15 ; and R15,R0,R7 ; or R2,R2,R2 ; addi R3,R0,5
        exec_alu("add",  32'h18918000, 1, 16'h0004, 16'h0008, 16'h0002, 5'b00011, 1'b0);
        exec_alu("sub",  32'h22CF8000, 2, 16'h0200, 16'h8000, 16'h0020, 5'b00100, 1'b0);
        exec_alu("and",  32'h2F838000, 1, 16'h0001, 16'h0080, 16'h8000, 5'b00101, 1'b0);
        exec_alu("or",   32'h31110000, 3, 16'h0004, 16'h0004, 16'h0004, 5'b00110, 1'b0);
        exec_alu("addi", 32'h61800005, 1, 16'h0001, 16'h0000, 16'h0008, 5'b00011, 1'b1);

        // ld R4,0x10(R5); stray mem_done in T4 must be ignored
        fetch("ld", 32'h02280010, 1);
        cyc("ld.T3",   1'b0, Y_IN,            16'h0,    16'h0020, 5'h0);
        cyc("ld.T4",   1'b1, C_OUT | Z_IN,    16'h0,    16'h0,    5'b00011);
        cyc("ld.T5",   1'b0, ZLO_OUT | MAR_IN, 16'h0,   16'h0,    5'h0);
        cyc("ld.T6W1", 1'b0, MEM_RD,          16'h0,    16'h0,    5'h0);
        cyc("ld.T6W2", 1'b0, MEM_RD,          16'h0,    16'h0,    5'h0);
        cyc("ld.T6W3", 1'b1, MEM_RD | MDR_IN, 16'h0,    16'h0,    5'h0);
        cyc("ld.T7",   1'b0, MDR_OUT,         16'h0010, 16'h0,    5'h0);

        // st R6,0x0(R7)
        fetch("st", 32'h13380000, 1);
        cyc("st.T3",   1'b0, Y_IN,             16'h0, 16'h0080, 5'h0);
        cyc("st.T4",   1'b0, C_OUT | Z_IN,     16'h0, 16'h0,    5'b00011);
        cyc("st.T5",   1'b0, ZLO_OUT | MAR_IN, 16'h0, 16'h0,    5'h0);
        cyc("st.T6",   1'b0, MDR_IN,           16'h0, 16'h0040, 5'h0);
        cyc("st.T7W1", 1'b0, MEM_WR,           16'h0, 16'h0,    5'h0);
        cyc("st.T7W2", 1'b1, MEM_WR,           16'h0, 16'h0,    5'h0);

        // nop and an undefined opcode (11111) both return to T0 after T3
        fetch("nop", 32'hD0000000, 1);
        cyc("nop.T3", 1'b0, 15'h0, 16'h0, 16'h0, 5'h0);
        fetch("ill", 32'hF8000000, 1);
        cyc("ill.T3", 1'b0, 15'h0, 16'h0, 16'h0, 5'h0);

        // halt: T3 quiet, then halted only, until clr
        fetch("halt", 32'hD8000000, 1);
        cyc("halt.T3", 1'b0, 15'h0, 16'h0, 16'h0, 5'h0);
        for (int i = 0; i < 20; i++)
            cyc("halt.hold", (i % 3) == 0, HALTED, 16'h0, 16'h0, 5'h0);
        do_reset("halt.clr");

        // clr wins over mem_done in the middle of the instruction read
        cyc("clr.T0", 1'b0, FETCH0, 16'h0, 16'h0, 5'h0);
        cyc("clr.T1", 1'b0, ZLO_OUT | PC_IN, 16'h0, 16'h0, 5'h0);
        bus.mem_done = 1'b1;
        @(negedge clk);
        check("clr.T1W", {12'h0, obs()}, {12'h0, MEM_RD | MDR_IN, 16'h0, 16'h0, 5'h0});
        do_reset("clr.flush");
        fetch("post", 32'hD0000000, 1);
        cyc("post.T3", 1'b0, 15'h0, 16'h0, 16'h0, 5'h0);

`ifdef CU_MEM_TIMEOUT_EN
        // no mem_done: fault after 15 wait cycles, sticky even if mem_done shows up later
        cyc("tmo.T0", 1'b0, FETCH0, 16'h0, 16'h0, 5'h0);
        cyc("tmo.T1", 1'b0, ZLO_OUT | PC_IN, 16'h0, 16'h0, 5'h0);
        for (int i = 0; i < 15; i++)
            cyc("tmo.T1W", 1'b0, MEM_RD, 16'h0, 16'h0, 5'h0);
        cyc("tmo.fault1", 1'b0, FLT, 16'h0, 16'h0, 5'h0);
        cyc("tmo.fault2", 1'b1, FLT, 16'h0, 16'h0, 5'h0);
        cyc("tmo.fault3", 1'b0, FLT, 16'h0, 16'h0, 5'h0);
        do_reset("tmo.clr");
        // mem_done on the 15th wait cycle completes normally
        fetch("tmo15", 32'hD0000000, 15);
        cyc("tmo15.T3", 1'b0, 15'h0, 16'h0, 16'h0, 5'h0);
`else
        // without the timeout a long wait just keeps waiting
        fetch("long", 32'hD0000000, 25);
        cyc("long.T3", 1'b0, 15'h0, 16'h0, 16'h0, 5'h0);
`endif
        cyc("end.T0", 1'b0, FETCH0, 16'h0, 16'h0, 5'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
